sr_latch_sequencer: RTL and testbench
=====================================

Name: sr_latch_sequencer

Overview:
- Clocked command sequencer for a bank of N SR latches.
- Accepts SET, RESET, TOGGLE and NOP commands over a valid/ready handshake and drives the selected latch's R or S input for a fixed pulse width.
- Waits a settle interval, then reads back Q and flags any mismatch.
- Guarantees the forbidden R=S=1 input is never driven on any latch; it is the only block allowed to drive the latch bank's R/S inputs.

Parameters:
- N, 4, number of latches in the bank
- SEL_W, 2, width of the latch select field (2**SEL_W >= N)
- PULSE_W, 2, cycles R or S is held high (legal range 1..15)
- SETTLE, 1, idle cycles between pulse end and Q check (legal range 0..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 NOP, 01 SET, 10 RESET, 11 TOGGLE
- cmd_sel  in  SEL_W  target latch index
- r_out  out  N  per-latch R drive
- s_out  out  N  per-latch S drive
- q_in  in  N  per-latch Q readback
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse, coincident with done
- err_cnt  out  8  saturating count of errors since reset

Behaviour:
- Reset:
  - One clock, synchronous and active-high; rst sampled high at a rising edge takes effect at that edge.
  - After reset: r_out=0, s_out=0, cmd_ready=1, busy=0, done=0, err=0, err_cnt=0, state IDLE.
- All outputs are registered.
- Acceptance:
  - A command is accepted on an edge where state is IDLE and cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE. It drops on the edge after acceptance.
- Operand capture: op, sel and the expected Q are captured at acceptance.
  - TOGGLE resolves using q_in[sel] sampled on the acceptance edge: Q=1 becomes RESET with expected 0; Q=0 becomes SET with expected 1.
  - SET expects 1. RESET expects 0.
- Select out of range (cmd_sel >= N):
  - No drive.
  - done=1 and err=1 on the edge after acceptance; err_cnt increments.
  - Return to IDLE.
- NOP: no drive; done=1 (err=0) on the edge after acceptance; return to IDLE.
- FSM: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
  - DRIVE: exactly one bit of s_out (SET) or r_out (RESET) at index sel is high, for exactly PULSE_W cycles starting the cycle after acceptance. All other bits are 0.
  - SETTLE: r_out=s_out=0 for SETTLE cycles. SETTLE=0 skips straight to CHECK.
  - CHECK: one cycle; compare q_in[sel] with expected. On the following edge: done=1, err=(mismatch), cmd_ready=1, busy=0.
  - A mismatch increments err_cnt, saturating at 255.
- Latency: for SET/RESET/TOGGLE, done is high in cycle PULSE_W+SETTLE+2 counted from acceptance (acceptance cycle = 0).
- busy=1 from the cycle after acceptance until done asserts. busy is low in the done cycle.
- Invariants, all cycles:
  - (r_out & s_out) == 0.
  - popcount(r_out | s_out) <= 1.
- Back-to-back: a command presented during the done cycle is accepted on that edge (cmd_ready=1). Its drive may start the next cycle.
- cmd_valid while not ready: ignored and not queued. The requester holds the command until it is accepted.
- Reset mid-operation: on the reset edge r_out/s_out clear and the command is dropped with no done or err pulse. err_cnt clears.

Test Plan:
- Reset, then SET sel=2, PULSE_W=2, SETTLE=1, latch model correct -> s_out=4'b0100 for cycles 1-2, 0 in cycle 3, done=1 with err=0 in cycle 5; cmd_ready=1 in cycle 5.
- TOGGLE sel=1 with q_in[1]=1 -> r_out=4'b0010 for 2 cycles, expected 0; model Q falls -> done=1, err=0. Then TOGGLE again -> s_out=4'b0010.
- RESET sel=0 with model Q stuck at 1 -> done=1, err=1, err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- Every cycle of a random command stream (2000 commands, random valid gaps) -> (r_out & s_out)==0 and at most one drive bit high, checked each cycle.
- Assert rst in the first DRIVE cycle -> r_out=s_out=0, busy=0, cmd_ready=1 next cycle; no done or err pulse ever for that command.
- NOP back-to-back with SET, valid held high -> NOP done in cycle 1, SET accepted in cycle 1, SET done in cycle 1+PULSE_W+SETTLE+2.

Source files
------------

// File: rtl/sr_latch_sequencer.sv
// Command sequencer for a bank of SR latches: pulses R or S on one latch,
// waits a settle interval, then verifies Q and counts mismatches.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | ready for a command; NOP / bad select complete here
// ST_DRIVE  | one R or S bit high for PULSE_W cycles
// ST_SETTLE | all drives low for SETTLE cycles
// ST_CHECK  | compare q_in[sel] with expected value
module sr_latch_sequencer #(
   parameter int N       = 4,
   parameter int SEL_W   = 2,
   parameter int PULSE_W = 2,
   parameter int SETTLE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [SEL_W-1:0] cmd_sel,
   output logic [N-1:0]     r_out,
   output logic [N-1:0]     s_out,
   input  logic [N-1:0]     q_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_cnt
);

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   localparam logic [3:0] PULSE_LAST  = 4'(PULSE_W - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_CHECK
   } state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [SEL_W-1:0] sel_q;
   logic             exp_q;

   logic             sel_ok;
   logic             drive_set;
   logic [N-1:0]     sel_hot;
   logic [7:0]       err_cnt_inc;
   logic             mismatch;

   assign sel_ok = int'(cmd_sel) < N;

   // TOGGLE becomes SET when the latch currently reads 0, RESET otherwise
   assign drive_set = (cmd_op == OP_SET) ||
                      ((cmd_op == OP_TOGGLE) && !q_in[cmd_sel]);

   assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   assign mismatch    = q_in[sel_q] != exp_q;

   always_comb begin
      sel_hot          = '0;
      sel_hot[cmd_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sel_q     <= '0;
         exp_q     <= 1'b0;
         r_out     <= '0;
         s_out     <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  sel_q <= cmd_sel;
                  if (cmd_op == OP_NOP) begin
                     done <= 1'b1;
                  end else if (!sel_ok) begin
                     done    <= 1'b1;
                     err     <= 1'b1;
                     err_cnt <= err_cnt_inc;
                  end else begin
                     exp_q     <= drive_set;
                     if (drive_set) s_out <= sel_hot;
                     else           r_out <= sel_hot;
                     cnt       <= PULSE_LAST;
                     state     <= ST_DRIVE;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            ST_DRIVE: begin
               if (cnt == 4'd0) begin
                  r_out <= '0;
                  s_out <= '0;
                  if (SETTLE == 0) begin
                     state <= ST_CHECK;
                  end else begin
                     state <= ST_SETTLE;
                     cnt   <= SETTLE_LAST;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_SETTLE: begin
               if (cnt == 4'd0) state <= ST_CHECK;
               else             cnt   <= cnt - 4'd1;
            end
            ST_CHECK: begin
               done      <= 1'b1;
               err       <= mismatch;
               if (mismatch) err_cnt <= err_cnt_inc;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed and random-stream bench for sr_latch_sequencer against a
// behavioural SR latch bank with optional stuck-at Q bits.
module tb_sr_latch_sequencer;

   localparam int N       = 4;
   localparam int SEL_W   = 2;
   localparam int PULSE_W = 2;
   localparam int SETTLE  = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [SEL_W-1:0] cmd_sel;
   logic [N-1:0]     r_out;
   logic [N-1:0]     s_out;
   logic [N-1:0]     q_in;
   logic             busy;
   logic             done;
   logic             err;
   logic [7:0]       err_cnt;

   logic [N-1:0] q_lat      = '0;
   logic [N-1:0] stuck_mask = '0;
   logic [N-1:0] stuck_val  = '0;

   int n_tests = 0;
   int n_fail  = 0;

   sr_latch_sequencer #(
      .N(N), .SEL_W(SEL_W), .PULSE_W(PULSE_W), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_sel(cmd_sel),
      .r_out(r_out), .s_out(s_out), .q_in(q_in),
      .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // latch bank responds mid-cycle to the registered drives
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (s_out[i])      q_lat[i] <= 1'b1;
         else if (r_out[i]) q_lat[i] <= 1'b0;
      end
   end

   assign q_in = (q_lat & ~stuck_mask) | (stuck_val & stuck_mask);

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      check("rs_overlap", 32'(r_out & s_out), 32'd0);
      check("one_drive", 32'($countones(r_out | s_out) <= 1), 32'd1);
   end

   // Issue a command at the current negedge (ready expected) and follow it
   // cycle by cycle up to its done cycle.
   task automatic run_cmd(input string tag, input logic [1:0] op,
                          input logic [1:0] sel, input logic [3:0] exp_r,
                          input logic [3:0] exp_s, input logic exp_err);
      check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < PULSE_W; k++) begin
         check({tag, "_r_drive"}, 32'(r_out), 32'(exp_r));
         check({tag, "_s_drive"}, 32'(s_out), 32'(exp_s));
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_not_ready"}, 32'(cmd_ready), 32'd0);
         check({tag, "_early_done"}, 32'(done), 32'd0);
         @(negedge clk);
      end
      for (int k = 0; k < SETTLE; k++) begin
         check({tag, "_settle_rs"}, 32'(r_out | s_out), 32'd0);
         check({tag, "_settle_busy"}, 32'(busy), 32'd1);
         @(negedge clk);
      end
      check({tag, "_check_rs"}, 32'(r_out | s_out), 32'd0);
      check({tag, "_check_done"}, 32'(done), 32'd0);
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_done_ready"}, 32'(cmd_ready), 32'd1);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int wait_cnt;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_sel   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_r", 32'(r_out), 32'd0);
      check("rst_s", 32'(s_out), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_errcnt", 32'(err_cnt), 32'd0);

      run_cmd("set2", 2'b01, 2'd2, 4'b0000, 4'b0100, 1'b0);
      run_cmd("set1", 2'b01, 2'd1, 4'b0000, 4'b0010, 1'b0);
      run_cmd("tog1a", 2'b11, 2'd1, 4'b0010, 4'b0000, 1'b0);
      run_cmd("tog1b", 2'b11, 2'd1, 4'b0000, 4'b0010, 1'b0);

      stuck_mask = 4'b0001;
      stuck_val  = 4'b0001;
      run_cmd("stuck_first", 2'b10, 2'd0, 4'b0001, 4'b0000, 1'b1);
      check("errcnt_1", 32'(err_cnt), 32'd1);
      for (int i = 2; i <= 300; i++) begin
         run_cmd("stuck_rep", 2'b10, 2'd0, 4'b0001, 4'b0000, 1'b1);
         if (i == 254 || i == 255 || i == 256 || i == 300)
            check("errcnt_sat", 32'(err_cnt), 32'(i > 255 ? 255 : i));
      end
      stuck_mask = '0;

      // NOP then SET back-to-back with valid held high
      cmd_op    = 2'b00;
      cmd_sel   = 2'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("nop_done", 32'(done), 32'd1);
      check("nop_err", 32'(err), 32'd0);
      check("nop_ready", 32'(cmd_ready), 32'd1);
      check("nop_busy", 32'(busy), 32'd0);
      cmd_op = 2'b01;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_s_c2", 32'(s_out), 32'd1);
      check("b2b_done_c2", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      check("b2b_done_c5", 32'(done), 32'd0);
      @(negedge clk);
      check("b2b_done_c6", 32'(done), 32'd1);
      check("b2b_err_c6", 32'(err), 32'd0);

      for (int c = 0; c < 2000; c++) begin
         cmd_valid  = 1'b0;
         stuck_mask = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
         stuck_val  = N'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         cmd_op    = 2'($urandom);
         cmd_sel   = SEL_W'($urandom);
         cmd_valid = 1'b1;
         wait_cnt  = 0;
         while (!cmd_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
         end
         if (wait_cnt >= 50) check("rand_accept_timeout", 32'(cmd_ready), 32'd1);
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      stuck_mask = '0;
      wait_cnt   = 0;
      while (!cmd_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("rand_drain_ready", 32'(cmd_ready), 32'd1);

      // reset during the first DRIVE cycle drops the command silently
      cmd_op    = 2'b01;
      cmd_sel   = 2'd3;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("mid_s_drive", 32'(s_out), 32'h8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rs", 32'(r_out | s_out), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_ready", 32'(cmd_ready), 32'd1);
      check("mid_errcnt", 32'(err_cnt), 32'd0);
      for (int k = 0; k < 8; k++) begin
         check("mid_no_done", 32'(done | err), 32'd0);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
